dsp_result_buffer: RTL and testbench

- Downstream stage of the DSP pre-add/multiply/post-add slice (fixed 4-cycle operand-to-P latency).
- Aligns a sideband valid with P, optionally accumulates N consecutive results, and queues words in a small FIFO.
- The FIFO drains over a ready/valid interface to the next consumer (writeback/DMA).
- Ends the slice's free-running output: no result is lost silently; drops are flagged.

---
 rtl/dsp_result_buffer_if.sv | 29 ++
 rtl/dsp_result_buffer.sv | 160 ++++++++++++++++
 tb/tb_dsp_result_buffer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_result_buffer_if.sv
// Result-stream bundle of the DSP result buffer: capture side, FIFO drain side and status.
// The slave modport is the buffer's view; master is the producer/consumer side.
interface dsp_result_buffer_if #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic [WIDTH-1:0] p_in;
  logic             acc_en;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             sat;
  logic             clr_flags;

  modport slave (
    input  in_valid, p_in, acc_en, out_ready, clr_flags,
    output out_data, out_valid, count, overflow, sat
  );

  modport master (
    output in_valid, p_in, acc_en, out_ready, clr_flags,
    input  out_data, out_valid, count, overflow, sat
  );
endinterface

// File: rtl/dsp_result_buffer.sv
// Aligns a sideband valid with the DSP P output, optionally accumulates ACC_LEN results,
// and queues words in a first-word-fall-through FIFO with sticky overflow/saturation flags.
//
// state   | meaning
// --------+----------------------------------------------------------------
// ST_PASS | every captured P is pushed unchanged
// ST_ACC  | captured P values are summed; one saturated word per ACC_LEN beats
module dsp_result_buffer #(
  parameter int LATENCY = 4,
  parameter int WIDTH   = 48,
  parameter int DEPTH   = 8,
  parameter int ACC_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  dsp_result_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(ACC_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(ACC_LEN - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LATENCY-1:0] r_vpipe;
  logic             w_cap;
  logic [BW-1:0]    r_beat;
  logic [BW-1:0]    w_beat_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_sum_sat;
  logic             w_carry;
  logic             w_push;
  logic [WIDTH-1:0] w_push_data;
  logic             w_sat_ev;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_wr;
  logic             w_drop;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_sat;

  // Valid delay line: P is only trusted LATENCY cycles after its operands.
  if (LATENCY == 1) begin : g_vpipe_one
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_vpipe <= '0;
      else     r_vpipe <= bus.in_valid;
    end
  end else begin : g_vpipe_multi
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_vpipe <= '0;
      else     r_vpipe <= {r_vpipe[LATENCY-2:0], bus.in_valid};
    end
  end

  assign w_cap = r_vpipe[LATENCY-1];

  assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, bus.p_in};
  assign w_sum_sat        = w_carry ? '1 : w_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_PASS;
      r_beat  <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_acc_nxt   = r_acc;
    w_push      = 1'b0;
    w_push_data = bus.p_in;
    w_sat_ev    = 1'b0;
    case (r_state)
      ST_PASS: begin
        if (w_cap) w_push = 1'b1;
      end
      ST_ACC: begin
        if (w_cap) begin
          w_sat_ev = w_carry;
          if (r_beat == LAST_BEAT) begin
            w_push      = 1'b1;
            w_push_data = w_sum_sat;
            w_acc_nxt   = '0;
            w_beat_nxt  = '0;
          end else begin
            w_acc_nxt  = w_sum_sat;
            w_beat_nxt = r_beat + 1'b1;
          end
        end
      end
      default: ;
    endcase
    // Mode only follows acc_en on a frame boundary, so a frame is never split.
    if (w_beat_nxt == '0) w_state_nxt = bus.acc_en ? ST_ACC : ST_PASS;
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = ~w_empty & bus.out_ready;
  // When full, a same-cycle pop frees the slot the write pointer lands on.
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      if (w_drop)             r_overflow <= 1'b1;
      else if (bus.clr_flags) r_overflow <= 1'b0;
      if (w_sat_ev)           r_sat      <= 1'b1;
      else if (bus.clr_flags) r_sat      <= 1'b0;
    end
  end

  assign bus.out_valid = ~w_empty;
  assign bus.out_data  = w_empty ? '0 : r_mem[r_rptr];
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;
  assign bus.sat       = r_sat;
endmodule

// File: tb/tb_dsp_result_buffer.sv
// Self-checking bench for dsp_result_buffer: a directed vector table, hand-written corner
// sequences and a long random run, all checked against a queue-based reference model.
module tb_dsp_result_buffer;
  localparam int LAT = 4;
  localparam int W   = 48;
  localparam int D   = 8;
  localparam int AL  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dsp_result_buffer_if #(.WIDTH(W), .DEPTH(D)) bus ();

  dsp_result_buffer #(.LATENCY(LAT), .WIDTH(W), .DEPTH(D), .ACC_LEN(AL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] mq[$];
  bit           vq[$];
  int           m_beat;
  bit           m_acc;
  logic [W-1:0] m_accv;
  bit           m_ovf;
  bit           m_sat;

  // Operands in flight through the DSP, so p_in shows the right value LAT cycles later
  logic [W-1:0] oq_v[$];
  bit           oq_ok[$];

  typedef struct {
    bit           iv;
    logic [W-1:0] p;
    bit           rdy;
    bit           ov;
    logic [W-1:0] data;
    int           cnt;
  } vec_t;

  vec_t         tbl[6];
  logic [W-1:0] exp_words[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    vq.delete();
    for (int i = 0; i < LAT; i++) vq.push_back(1'b0);
    m_beat = 0;
    m_acc  = 1'b0;
    m_accv = '0;
    m_ovf  = 1'b0;
    m_sat  = 1'b0;
  endtask

  task automatic model_step();
    bit           cap, pop, push, full, ovf_ev, sat_ev;
    logic [W-1:0] word;
    logic [W:0]   wide;
    cap    = vq.pop_front();
    vq.push_back(bus.in_valid);
    full   = (mq.size() == D);
    pop    = (mq.size() > 0) && bus.out_ready;
    push   = 1'b0;
    ovf_ev = 1'b0;
    sat_ev = 1'b0;
    word   = bus.p_in;
    if (cap) begin
      if (!m_acc) begin
        push = 1'b1;
      end else begin
        wide = {1'b0, m_accv} + {1'b0, bus.p_in};
        if (wide > {1'b0, {W{1'b1}}}) begin
          wide   = {1'b0, {W{1'b1}}};
          sat_ev = 1'b1;
        end
        if (m_beat < AL - 1) begin
          m_accv = wide[W-1:0];
          m_beat++;
        end else begin
          push   = 1'b1;
          word   = wide[W-1:0];
          m_accv = '0;
          m_beat = 0;
        end
      end
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (full && !pop) ovf_ev = 1'b1;
      else              mq.push_back(word);
    end
    if (m_beat == 0) m_acc = bus.acc_en;
    if (ovf_ev) m_ovf = 1'b1; else if (bus.clr_flags) m_ovf = 1'b0;
    if (sat_ev) m_sat = 1'b1; else if (bus.clr_flags) m_sat = 1'b0;
  endtask

  task automatic compare_model();
    chk("model_out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
    chk("model_out_data", 64'(bus.out_data), (mq.size() > 0) ? 64'(mq[0]) : 64'd0);
    chk("model_count", 64'(bus.count), 64'(mq.size()));
    chk("model_overflow", 64'(bus.overflow), 64'(m_ovf));
    chk("model_sat", 64'(bus.sat), 64'(m_sat));
  endtask

  task automatic cycle();
    if (rst) model_reset();
    else     model_step();
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic oq_reset();
    oq_v.delete();
    oq_ok.delete();
    for (int i = 0; i < LAT; i++) begin
      oq_v.push_back('0);
      oq_ok.push_back(1'b0);
    end
  endtask

  task automatic issue(input bit iv, input logic [W-1:0] v);
    logic [63:0] junk;
    junk         = {$urandom(), $urandom()};
    bus.in_valid = iv;
    bus.p_in     = oq_ok[0] ? oq_v[0] : junk[W-1:0];
    void'(oq_v.pop_front());
    void'(oq_ok.pop_front());
    oq_v.push_back(v);
    oq_ok.push_back(iv);
    cycle();
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.p_in      = '0;
    bus.acc_en    = 1'b0;
    bus.out_ready = 1'b0;
    bus.clr_flags = 1'b0;
    oq_reset();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic drain_check(input string name);
    bus.in_valid = 1'b0;
    foreach (exp_words[j]) begin
      chk({name, "_word"}, 64'(bus.out_data), 64'(exp_words[j]));
      bus.out_ready = 1'b1;
      issue(1'b0, '0);
    end
    bus.out_ready = 1'b0;
    chk({name, "_empty"}, 64'(bus.count), 64'd0);
  endtask

  initial begin
    // PASS pulse: capture at cycle LAT, word visible one cycle later and popped at once
    tbl[0] = '{iv: 1'b1, p: 48'h0,              rdy: 1'b1, ov: 1'b0, data: 48'h0,    cnt: 0};
    tbl[1] = '{iv: 1'b0, p: 48'hFFFF_0000_FFFF, rdy: 1'b1, ov: 1'b0, data: 48'h0,    cnt: 0};
    tbl[2] = '{iv: 1'b0, p: 48'h5555_5555_5555, rdy: 1'b1, ov: 1'b0, data: 48'h0,    cnt: 0};
    tbl[3] = '{iv: 1'b0, p: 48'h0,              rdy: 1'b1, ov: 1'b0, data: 48'h0,    cnt: 0};
    tbl[4] = '{iv: 1'b0, p: 48'h0000_0000_1234, rdy: 1'b1, ov: 1'b1, data: 48'h1234, cnt: 1};
    tbl[5] = '{iv: 1'b0, p: 48'h0,              rdy: 1'b1, ov: 1'b0, data: 48'h0,    cnt: 0};

    do_reset();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);
    chk("rst_sat", 64'(bus.sat), 64'd0);

    for (int i = 0; i < 6; i++) begin
      bus.in_valid  = tbl[i].iv;
      bus.p_in      = tbl[i].p;
      bus.out_ready = tbl[i].rdy;
      cycle();
      chk("t1_out_valid", 64'(bus.out_valid), 64'(tbl[i].ov));
      chk("t1_out_data", 64'(bus.out_data), 64'(tbl[i].data));
      chk("t1_count", 64'(bus.count), 64'(tbl[i].cnt));
    end

    // Accumulate 10+20+30+40, no partial sums leak out
    do_reset();
    bus.acc_en = 1'b1;
    issue(1'b0, '0);
    for (int k = 0; k < LAT + 5; k++) begin
      logic [W-1:0] v;
      v = (k < 4) ? W'((k + 1) * 10) : '0;
      issue(k < 4, v);
      if (k < LAT + 3) chk("t2_no_partial", 64'(bus.count), 64'd0);
    end
    chk("t2_count", 64'(bus.count), 64'd1);
    chk("t2_sum", 64'(bus.out_data), 64'd100);

    // Saturating accumulation, then flag clear
    do_reset();
    bus.acc_en = 1'b1;
    issue(1'b0, '0);
    issue(1'b1, 48'hFFFF_FFFF_FFF0);
    issue(1'b1, 48'h20);
    issue(1'b1, 48'h0);
    issue(1'b1, 48'h0);
    for (int k = 0; k < LAT; k++) issue(1'b0, '0);
    chk("t3_sat_word", 64'(bus.out_data), 64'hFFFF_FFFF_FFFF);
    chk("t3_sat_flag", 64'(bus.sat), 64'd1);
    bus.clr_flags = 1'b1;
    issue(1'b0, '0);
    bus.clr_flags = 1'b0;
    chk("t3_sat_clr", 64'(bus.sat), 64'd0);

    // Overflow on a stalled consumer, then push+pop while full
    do_reset();
    for (int k = 0; k < 10 + LAT; k++) begin
      bus.out_ready = (k == 9 + LAT);
      issue(k < 10, W'(k + 1));
      if (k == 8 + LAT) begin
        chk("t4_full_count", 64'(bus.count), 64'd8);
        chk("t4_overflow", 64'(bus.overflow), 64'd1);
      end
    end
    bus.out_ready = 1'b0;
    chk("t4_pushpop_count", 64'(bus.count), 64'd8);
    exp_words.delete();
    for (int j = 2; j <= 8; j++) exp_words.push_back(W'(j));
    exp_words.push_back(W'(10));
    drain_check("t4_drain");
    bus.clr_flags = 1'b1;
    issue(1'b0, '0);
    bus.clr_flags = 1'b0;
    chk("t4_ovf_clr", 64'(bus.overflow), 64'd0);

    // acc_en drops mid-frame: frame completes, then pass-through
    do_reset();
    bus.acc_en = 1'b1;
    issue(1'b0, '0);
    for (int k = 0; k < LAT + 6; k++) begin
      logic [W-1:0] v;
      case (k)
        0: v = 48'd1;
        1: v = 48'd2;
        2: v = 48'd3;
        3: v = 48'd4;
        4: v = 48'd100;
        5: v = 48'd200;
        default: v = '0;
      endcase
      bus.acc_en = (k < LAT + 2);
      issue(k < 6, v);
      if (k == LAT + 2) chk("t5_mid_frame", 64'(bus.count), 64'd0);
    end
    chk("t5_count", 64'(bus.count), 64'd3);
    exp_words.delete();
    exp_words.push_back(48'd10);
    exp_words.push_back(48'd100);
    exp_words.push_back(48'd200);
    drain_check("t5_drain");

    // Async reset mid-frame with words queued
    do_reset();
    for (int k = 0; k < 3 + LAT; k++) issue(k < 3, W'(k + 7));
    bus.acc_en = 1'b1;
    issue(1'b0, '0);
    issue(1'b1, 48'd5);
    issue(1'b1, 48'd6);
    for (int k = 0; k < LAT; k++) issue(1'b0, '0);
    chk("t6_pre_count", 64'(bus.count), 64'd3);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_async_count", 64'(bus.count), 64'd0);
    oq_reset();
    bus.in_valid = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      issue(1'b0, '0);
      chk("t6_no_capture", 64'(bus.count), 64'd0);
    end
    for (int k = 0; k < 4; k++) issue(1'b1, W'(k + 1));
    for (int k = 0; k < LAT; k++) issue(1'b0, '0);
    chk("t6_fresh_count", 64'(bus.count), 64'd1);
    chk("t6_fresh_sum", 64'(bus.out_data), 64'd10);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] v;
      int           rdy_pct;
      rdy_pct = ((i / 400) % 2 == 0) ? 70 : 20;
      if ($urandom_range(0, 39) == 0) bus.acc_en = ~bus.acc_en;
      bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
      bus.clr_flags = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) v = {16'hFFFF, $urandom()};
      else                           v = W'($urandom_range(0, 1_000_000));
      issue($urandom_range(0, 1) == 1, v);
    end
    bus.clr_flags = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
